// File: rtl/decode_queue_pkg.sv
// Shared RV32I decode definitions: team op codes, major opcodes and the queue entry payload.
package decode_queue_pkg;

  localparam int unsigned XLEN_P = 32;
  localparam int unsigned OP_W   = 7;
  localparam int unsigned REG_W  = 5;

  typedef enum logic [OP_W-1:0] {
    OP_ILLEGAL = 7'd0,
    OP_LUI     = 7'd1,
    OP_AUIPC   = 7'd2,
    OP_JAL     = 7'd3,
    OP_JALR    = 7'd4,
    OP_BEQ     = 7'd5,
    OP_BNE     = 7'd6,
    OP_BLT     = 7'd7,
    OP_BGE     = 7'd8,
    OP_BLTU    = 7'd9,
    OP_BGEU    = 7'd10,
    OP_LB      = 7'd11,
    OP_LH      = 7'd12,
    OP_LW      = 7'd13,
    OP_LBU     = 7'd14,
    OP_LHU     = 7'd15,
    OP_SB      = 7'd16,
    OP_SH      = 7'd17,
    OP_SW      = 7'd18,
    OP_ADDI    = 7'd19,
    OP_SLTI    = 7'd20,
    OP_SLTIU   = 7'd21,
    OP_XORI    = 7'd22,
    OP_ORI     = 7'd23,
    OP_ANDI    = 7'd24,
    OP_SLLI    = 7'd25,
    OP_SRLI    = 7'd26,
    OP_SRAI    = 7'd27,
    OP_ADD     = 7'd28,
    OP_SUB     = 7'd29,
    OP_SLL     = 7'd30,
    OP_SLT     = 7'd31,
    OP_SLTU    = 7'd32,
    OP_XOR     = 7'd33,
    OP_SRL     = 7'd34,
    OP_SRA     = 7'd35,
    OP_OR      = 7'd36,
    OP_AND     = 7'd37
  } op_e;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opc_e;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [XLEN_P-1:0] imm;
    logic              illegal;
    logic [XLEN_P-1:0] pc;
    logic              pred;
  } dq_entry_t;

endpackage

// File: rtl/decode_queue_inst_decode_core.sv
// Pure combinational RV32I decoder: raw instruction word -> team op code, register fields, immediate.
module decode_queue_inst_decode_core
  import decode_queue_pkg::*;
(
  input  logic [XLEN_P-1:0] i_inst,
  output logic [OP_W-1:0]   o_op,
  output logic [REG_W-1:0]  o_rd,
  output logic [REG_W-1:0]  o_rs1,
  output logic [REG_W-1:0]  o_rs2,
  output logic [XLEN_P-1:0] o_imm,
  output logic              o_illegal
);

  logic [6:0]        w_opc;
  logic [2:0]        w_f3;
  logic [6:0]        w_f7;
  logic [XLEN_P-1:0] w_imm_i;
  logic [XLEN_P-1:0] w_imm_s;
  logic [XLEN_P-1:0] w_imm_b;
  logic [XLEN_P-1:0] w_imm_j;
  logic [XLEN_P-1:0] w_imm_u;
  logic [XLEN_P-1:0] w_imm_sh;
  logic [XLEN_P-1:0] w_imm_raw;
  op_e               w_op;

  assign w_opc = i_inst[6:0];
  assign w_f3  = i_inst[14:12];
  assign w_f7  = i_inst[31:25];

  assign w_imm_i  = {{20{i_inst[31]}}, i_inst[31:20]};
  assign w_imm_s  = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
  assign w_imm_b  = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
  assign w_imm_j  = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
  assign w_imm_u  = {i_inst[31:12], 12'b0};
  assign w_imm_sh = {27'b0, i_inst[24:20]};

  // Op selection; any encoding not matched below stays OP_ILLEGAL
  always_comb begin
    w_op      = OP_ILLEGAL;
    w_imm_raw = '0;
    case (w_opc)
      OPC_LUI: begin
        w_op      = OP_LUI;
        w_imm_raw = w_imm_u;
      end
      OPC_AUIPC: begin
        w_op      = OP_AUIPC;
        w_imm_raw = w_imm_u;
      end
      OPC_JAL: begin
        w_op      = OP_JAL;
        w_imm_raw = w_imm_j;
      end
      OPC_JALR: begin
        w_imm_raw = w_imm_i;
        if (w_f3 == 3'b000) w_op = OP_JALR;
      end
      OPC_BRANCH: begin
        w_imm_raw = w_imm_b;
        case (w_f3)
          3'b000:  w_op = OP_BEQ;
          3'b001:  w_op = OP_BNE;
          3'b100:  w_op = OP_BLT;
          3'b101:  w_op = OP_BGE;
          3'b110:  w_op = OP_BLTU;
          3'b111:  w_op = OP_BGEU;
          default: w_op = OP_ILLEGAL;
        endcase
      end
      OPC_LOAD: begin
        w_imm_raw = w_imm_i;
        case (w_f3)
          3'b000:  w_op = OP_LB;
          3'b001:  w_op = OP_LH;
          3'b010:  w_op = OP_LW;
          3'b100:  w_op = OP_LBU;
          3'b101:  w_op = OP_LHU;
          default: w_op = OP_ILLEGAL;
        endcase
      end
      OPC_STORE: begin
        w_imm_raw = w_imm_s;
        case (w_f3)
          3'b000:  w_op = OP_SB;
          3'b001:  w_op = OP_SH;
          3'b010:  w_op = OP_SW;
          default: w_op = OP_ILLEGAL;
        endcase
      end
      OPC_OP_IMM: begin
        w_imm_raw = w_imm_i;
        case (w_f3)
          3'b000: w_op = OP_ADDI;
          3'b010: w_op = OP_SLTI;
          3'b011: w_op = OP_SLTIU;
          3'b100: w_op = OP_XORI;
          3'b110: w_op = OP_ORI;
          3'b111: w_op = OP_ANDI;
          3'b001: begin
            w_imm_raw = w_imm_sh;
            if (w_f7 == F7_BASE) w_op = OP_SLLI;
          end
          default: begin
            w_imm_raw = w_imm_sh;
            if (w_f7 == F7_BASE)     w_op = OP_SRLI;
            else if (w_f7 == F7_ALT) w_op = OP_SRAI;
          end
        endcase
      end
      OPC_OP: begin
        if (w_f7 == F7_BASE) begin
          case (w_f3)
            3'b000:  w_op = OP_ADD;
            3'b001:  w_op = OP_SLL;
            3'b010:  w_op = OP_SLT;
            3'b011:  w_op = OP_SLTU;
            3'b100:  w_op = OP_XOR;
            3'b101:  w_op = OP_SRL;
            3'b110:  w_op = OP_OR;
            default: w_op = OP_AND;
          endcase
        end else if (w_f7 == F7_ALT) begin
          if (w_f3 == 3'b000)      w_op = OP_SUB;
          else if (w_f3 == 3'b101) w_op = OP_SRA;
        end
      end
      default: w_op = OP_ILLEGAL;
    endcase
  end

  assign o_op      = w_op;
  assign o_illegal = (w_op == OP_ILLEGAL);
  assign o_imm     = o_illegal ? '0 : w_imm_raw;
  assign o_rd      = i_inst[11:7];
  assign o_rs1     = i_inst[19:15];
  assign o_rs2     = i_inst[24:20];

endmodule

// File: rtl/decode_queue.sv
// Decoded-instruction FIFO between IF and dispatch: decode on write, valid/ready pop,
// flush on mispredict and a global freeze via rdy_in.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int unsigned QUEUE_WIDTH = 2,
  parameter int unsigned XLEN        = 32,
  parameter int unsigned OP_WIDTH    = 7
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                flush_in,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XLEN-1:0]     in_inst,
  input  logic [XLEN-1:0]     in_pc,
  input  logic                in_pred,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OP_WIDTH-1:0] out_op,
  output logic [4:0]          out_rd,
  output logic [4:0]          out_rs1,
  output logic [4:0]          out_rs2,
  output logic [XLEN-1:0]     out_imm,
  output logic [XLEN-1:0]     out_pc,
  output logic                out_pred,
  output logic                out_illegal
);

  localparam int unsigned DEPTH = 1 << QUEUE_WIDTH;
  localparam int unsigned CW    = QUEUE_WIDTH + 1;

  logic [QUEUE_WIDTH-1:0] r_head;
  logic [QUEUE_WIDTH-1:0] r_tail;
  logic [CW-1:0]          r_count;
  dq_entry_t              r_mem [DEPTH];

  logic [OP_W-1:0]   w_dec_op;
  logic [REG_W-1:0]  w_dec_rd;
  logic [REG_W-1:0]  w_dec_rs1;
  logic [REG_W-1:0]  w_dec_rs2;
  logic [XLEN_P-1:0] w_dec_imm;
  logic              w_dec_illegal;
  dq_entry_t         w_wr_entry;
  dq_entry_t         w_head;
  logic              w_push;
  logic              w_pop;

  decode_queue_inst_decode_core u_decode (
    .i_inst    (XLEN_P'(in_inst)),
    .o_op      (w_dec_op),
    .o_rd      (w_dec_rd),
    .o_rs1     (w_dec_rs1),
    .o_rs2     (w_dec_rs2),
    .o_imm     (w_dec_imm),
    .o_illegal (w_dec_illegal)
  );

  always_comb begin
    w_wr_entry         = '0;
    w_wr_entry.op      = w_dec_op;
    w_wr_entry.rd      = w_dec_rd;
    w_wr_entry.rs1     = w_dec_rs1;
    w_wr_entry.rs2     = w_dec_rs2;
    w_wr_entry.imm     = w_dec_imm;
    w_wr_entry.illegal = w_dec_illegal;
    w_wr_entry.pc      = XLEN_P'(in_pc);
    w_wr_entry.pred    = in_pred;
  end

  // Handshake flags come only from registered count, so no input reaches an output combinationally
  assign in_ready  = (r_count != CW'(DEPTH));
  assign out_valid = (r_count != CW'(0));

  assign w_push = in_valid  & in_ready  & rdy_in & ~flush_in;
  assign w_pop  = out_valid & out_ready & rdy_in & ~flush_in;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_tail <= r_tail + QUEUE_WIDTH'(1);
        if (w_pop)  r_head <= r_head + QUEUE_WIDTH'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Storage is deliberately left uncleared by reset; empty-queue outputs are masked below
  always_ff @(posedge clk_in) begin
    if (!rst_in && w_push) r_mem[r_tail] <= w_wr_entry;
  end

  assign w_head = r_mem[r_head];

  assign out_op      = out_valid ? OP_WIDTH'(w_head.op) : '0;
  assign out_rd      = out_valid ? w_head.rd            : '0;
  assign out_rs1     = out_valid ? w_head.rs1           : '0;
  assign out_rs2     = out_valid ? w_head.rs2           : '0;
  assign out_imm     = out_valid ? XLEN'(w_head.imm)    : '0;
  assign out_pc      = out_valid ? XLEN'(w_head.pc)     : '0;
  assign out_pred    = out_valid ? w_head.pred          : 1'b0;
  assign out_illegal = out_valid ? w_head.illegal       : 1'b0;

endmodule
